id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Hazard and issue controller for the decode stage. It tracks destination registers in flight through EX, MEM and WB, and stalls the ID stage on load-use hazards. It drives forwarding selects for both source operands and inserts bubbles on stall or on a branch/jump redirect. It sits beside ID_stage, taking decoded register fields from decoder_stage and steering operand muxes ahead of EX.

## Interface
- STALL_CNT_W, 16, width of the saturating stall performance counter
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a valid instruction
- id_rs1_addr  in  5  source 1 register
- id_rs2_addr  in  5  source 2 register
- id_uses_rs1  in  1  instruction reads rs1
- id_uses_rs2  in  1  instruction reads rs2 (R, S, B types)
- id_rd_addr  in  5  destination register
- id_writes_rd  in  1  instruction writes rd
- id_is_load  in  1  instruction is a load
- flush  in  1  redirect resolved in EX; kill the instruction currently in ID
- stall  out  1  hold PC and the IF/ID register this cycle
- issue  out  1  ID instruction advances into EX this cycle
- fwd_rs1_sel  out  2  0 = regfile, 1 = EX result, 2 = MEM result, 3 = WB result
- fwd_rs2_sel  out  2  same encoding for rs2
- busy_map  out  32  bit n set if any valid in-flight slot writes xn; bit 0 always 0
- stall_count  out  STALL_CNT_W  number of stall cycles since reset, saturating

## Operation
- Three tracking slots: EX, MEM, WB. Each slot holds {valid, rd, is_load}.
- A slot counts as "writes" only when it is valid, writes rd, and rd != 0. Register x0 never creates a hazard or a forward.
- Source match: a used source (uses_rsN = 1) with a nonzero address equal to a writing slot's rd.
- Load-use hazard: the EX slot is a load and matches either used source, and id_valid = 1.
- stall = hazard & ~flush.
- issue = id_valid & ~stall & ~flush.
- Forward priority, per source: EX (1), then MEM (2), then WB (3), otherwise 0. The youngest producer wins.
- If a source matches a load in EX, fwd_sel for that source is don't-care; stall is asserted.
- Slot update every cycle:
  - WB <= MEM
  - MEM <= EX
  - EX <= {issue & id_writes_rd, id_rd_addr, id_is_load}
  - When issue = 0, a bubble (valid = 0) enters EX.
- flush kills only the ID instruction. The redirecting instruction already in EX proceeds, so a jal/jalr rd write completes.
- Simultaneous flush and hazard: flush wins. stall = 0, issue = 0, and the bubble enters EX.
- stall_count increments on each cycle with stall = 1 and holds at all-ones.
- busy_map is the OR of the one-hot rd of every writing slot.

## Timing
- stall, issue, fwd_*_sel and busy_map are combinational from the slot registers and ID inputs, with zero-cycle latency.
- Slots and stall_count update on the rising edge of clk.
- A load-use stall lasts exactly 1 cycle. The next cycle the load is in MEM, so fwd_sel = 2.
- Dependency distance 1 (non-load) gives sel 1. Distance 2 gives sel 2. Distance 3 gives sel 3. Distance 4 or more gives 0, because the regfile write has completed.
- Reset, including reset mid-operation: all slots invalid, stall_count = 0. Outputs then read stall = 0, fwd_sel = 0, busy_map = 0, and issue = id_valid.
- Reset overrides flush and all ID inputs in the same cycle.

## Structure
- A shared package holds:
  - forwarding select constants (FWD_RF = 0, FWD_EX = 1, FWD_MEM = 2, FWD_WB = 3)
  - the register address width (5)
  - the slot record layout
- Sub-module hazard_slot: one registered {valid, rd, is_load} entry with its "writes" and match-against-rs1/rs2 logic. It is instantiated three times.
- Priority and stall logic stays in the top level.

## Test plan
- add x5,x6,x7 (0x007302b3) issued, then add x8,x5,x9 the next cycle -> fwd_rs1_sel = 1, stall = 0.
- lw x5,8(x3) (0x0081a283), then add x6,x5,x7 -> stall = 1 for one cycle and stall_count = 1. The next cycle fwd_rs1_sel = 2 and issue = 1.
- addi x0,x0,1, then add x1,x0,x0 -> both fwd_sel = 0, stall = 0, busy_map = 0.
- add x5 three instructions before a consumer of x5 gives fwd_sel = 3. Four instructions before gives fwd_sel = 0.
- Load-use hazard with flush = 1 in the same cycle -> stall = 0, issue = 0. The EX slot is a bubble next cycle and stall_count is unchanged.
- Pulse rst with all three slots valid -> next cycle busy_map = 0, stall_count = 0. Drive stall_count to 0xFFFF and hold a hazard -> it stays at 0xFFFF.

Source files
------------

// File: rtl/id_hazard_ctrl_pkg.sv
// id_hazard_ctrl_pkg: shared forwarding encodings and in-flight slot record layout
package id_hazard_ctrl_pkg;
    localparam int REG_AW = 5;
    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;
    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              is_load;
    } slot_t;
    localparam int SLOT_W = $bits(slot_t);
endpackage

// File: rtl/id_hazard_ctrl_hazard_slot.sv
// hazard_slot: one in-flight pipeline entry with its write-qualify and source-match logic
module hazard_slot
    import id_hazard_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [SLOT_W-1:0] slot_in,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    input  logic              uses_rs1,
    input  logic              uses_rs2,
    output logic [SLOT_W-1:0] slot_out,
    output logic              writes,
    output logic              match_rs1,
    output logic              match_rs2
);
    slot_t slot_d, slot_q;
    always_comb begin
        slot_d    = slot_t'(slot_in);
        slot_out  = slot_q;
        writes    = slot_q.valid && (slot_q.rd != '0);
        match_rs1 = writes && uses_rs1 && (rs1_addr == slot_q.rd);
        match_rs2 = writes && uses_rs2 && (rs2_addr == slot_q.rd);
    end
    always_ff @(posedge clk) begin
        if (rst) slot_q <= '0;
        else     slot_q <= slot_d;
    end
endmodule

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage load-use stall, operand forwarding select and bubble insertion
module id_hazard_ctrl
    import id_hazard_ctrl_pkg::*;
#(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic                   id_uses_rs1,
    input  logic                   id_uses_rs2,
    input  logic [4:0]             id_rd_addr,
    input  logic                   id_writes_rd,
    input  logic                   id_is_load,
    input  logic                   flush,
    output logic                   stall,
    output logic                   issue,
    output logic [1:0]             fwd_rs1_sel,
    output logic [1:0]             fwd_rs2_sel,
    output logic [31:0]            busy_map,
    output logic [STALL_CNT_W-1:0] stall_count
);
    slot_t slot_i [3];
    slot_t slot_o [3];
    logic [2:0] wr, m1, m2;
    logic hazard;
    logic [STALL_CNT_W-1:0] stall_count_d, stall_count_q;
    // slot 0 = EX, 1 = MEM, 2 = WB; each shifts into the next every cycle
    for (genvar i = 0; i < 3; i++) begin : g_slot
        hazard_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .slot_in   (slot_i[i]),
            .rs1_addr  (id_rs1_addr),
            .rs2_addr  (id_rs2_addr),
            .uses_rs1  (id_uses_rs1),
            .uses_rs2  (id_uses_rs2),
            .slot_out  (slot_o[i]),
            .writes    (wr[i]),
            .match_rs1 (m1[i]),
            .match_rs2 (m2[i])
        );
    end
    always_comb begin
        hazard        = id_valid && slot_o[0].is_load && (m1[0] || m2[0]);
        stall         = hazard && !flush;
        issue         = id_valid && !stall && !flush;
        slot_i[0]     = '{valid: issue && id_writes_rd, rd: id_rd_addr, is_load: id_is_load};
        slot_i[1]     = slot_o[0];
        slot_i[2]     = slot_o[1];
        fwd_rs1_sel   = m1[0] ? FWD_EX : m1[1] ? FWD_MEM : m1[2] ? FWD_WB : FWD_RF;
        fwd_rs2_sel   = m2[0] ? FWD_EX : m2[1] ? FWD_MEM : m2[2] ? FWD_WB : FWD_RF;
        busy_map      = '0;
        for (int k = 0; k < 3; k++) if (wr[k]) busy_map[slot_o[k].rd] = 1'b1;
        stall_count_d = (stall && stall_count_q != '1) ? stall_count_q + 1'b1 : stall_count_q;
        stall_count   = stall_count_q;
    end
    always_ff @(posedge clk) begin
        if (rst) stall_count_q <= '0;
        else     stall_count_q <= stall_count_d;
    end
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed RISC-V scenarios plus randomized run against an issue-history model
module tb_id_hazard_ctrl;
    logic clk = 1'b0, rst = 1'b0;
    logic id_valid = 1'b0, id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_writes_rd = 1'b0, id_is_load = 1'b0, flush = 1'b0;
    logic [4:0] id_rs1_addr = '0, id_rs2_addr = '0, id_rd_addr = '0;
    logic stall, issue, s_stall, s_issue;
    logic [1:0] fwd_rs1_sel, fwd_rs2_sel, s_sel1, s_sel2;
    logic [31:0] busy_map, s_busy;
    logic [15:0] stall_count;
    logic [2:0] s_count;
    int pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    id_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd_addr(id_rd_addr), .id_writes_rd(id_writes_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(stall), .issue(issue), .fwd_rs1_sel(fwd_rs1_sel),
        .fwd_rs2_sel(fwd_rs2_sel), .busy_map(busy_map), .stall_count(stall_count)
    );
    id_hazard_ctrl #(.STALL_CNT_W(3)) u_sat (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd_addr(id_rd_addr), .id_writes_rd(id_writes_rd),
        .id_is_load(id_is_load), .flush(flush), .stall(s_stall), .issue(s_issue), .fwd_rs1_sel(s_sel1),
        .fwd_rs2_sel(s_sel2), .busy_map(s_busy), .stall_count(s_count)
    );

    // Reference model: history of the last three cycles' issue results, newest first
    typedef struct {bit w; bit [4:0] rd; bit ld;} rec_t;
    rec_t hist[$];
    int unsigned mcnt = 0;

    // Returns forwarding distance (1..3), 0 for regfile, -1 when the source hits a load one cycle ahead
    function automatic int exp_sel(logic u, logic [4:0] a);
        if (!u || a == 0) return 0;
        for (int d = 0; d < hist.size() && d < 3; d++)
            if (hist[d].w && hist[d].rd == a) return (d == 0 && hist[d].ld) ? -1 : d + 1;
        return 0;
    endfunction
    function automatic bit exp_stall();
        return id_valid && !flush && (exp_sel(id_uses_rs1, id_rs1_addr) == -1 || exp_sel(id_uses_rs2, id_rs2_addr) == -1);
    endfunction
    function automatic bit exp_issue();
        return id_valid && !flush && !exp_stall();
    endfunction
    function automatic logic [31:0] exp_busy();
        logic [31:0] b = '0;
        for (int d = 0; d < hist.size() && d < 3; d++) if (hist[d].w && hist[d].rd != 0) b[hist[d].rd] = 1'b1;
        return b;
    endfunction

    always @(posedge clk) begin
        rec_t r;
        if (rst) begin
            hist.delete();
            mcnt = 0;
        end else begin
            if (exp_stall() && mcnt < 65535) mcnt++;
            r.w = exp_issue() && id_writes_rd;
            r.rd = id_rd_addr;
            r.ld = id_is_load;
            hist.push_front(r);
            if (hist.size() > 3) void'(hist.pop_back());
        end
    end

    function automatic logic [31:0] rtype(int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
    endfunction

    // Drive one instruction word into ID on the falling edge, then let outputs settle
    task automatic put(input logic [31:0] ins, input logic v, input logic fl);
        logic [6:0] op;
        @(negedge clk);
        op = ins[6:0];
        id_valid = v;
        flush = fl;
        id_rd_addr = ins[11:7];
        id_rs1_addr = ins[19:15];
        id_rs2_addr = ins[24:20];
        id_uses_rs1 = (op == 7'h33) || (op == 7'h03) || (op == 7'h13);
        id_uses_rs2 = (op == 7'h33);
        id_writes_rd = (op == 7'h33) || (op == 7'h03) || (op == 7'h13);
        id_is_load = (op == 7'h03);
        #1;
    endtask

    task automatic do_rst();
        @(negedge clk);
        rst = 1'b1;
        id_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b1;
        id_valid = 1'b1;
        id_is_load = 1'b1;
        id_writes_rd = 1'b1;
        id_rd_addr = 5'd9;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        id_uses_rs1 = 1'b1;
        id_rs1_addr = 5'd9;
        #1;
        total++; if (stall !== 1'b0) $display("FAIL reset_stall got %b want 0", stall); else pass_cnt++;
        total++; if (issue !== 1'b1) $display("FAIL reset_issue got %b want 1", issue); else pass_cnt++;
        total++; if (fwd_rs1_sel !== 2'd0) $display("FAIL reset_sel1 got %0d want 0", fwd_rs1_sel); else pass_cnt++;
        total++; if (busy_map !== 32'd0) $display("FAIL reset_busy got %h want 0", busy_map); else pass_cnt++;
        total++; if (stall_count !== 16'd0) $display("FAIL reset_count got %0d want 0", stall_count); else pass_cnt++;
    endtask

    task automatic test_fwd_ex();
        do_rst();
        put(32'h007302b3, 1, 0);
        put(32'h00928433, 1, 0);
        total++; if (fwd_rs1_sel !== 2'd1) $display("FAIL fwd_ex_sel1 got %0d want 1", fwd_rs1_sel); else pass_cnt++;
        total++; if (fwd_rs2_sel !== 2'd0) $display("FAIL fwd_ex_sel2 got %0d want 0", fwd_rs2_sel); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL fwd_ex_stall got %b want 0", stall); else pass_cnt++;
        total++; if (busy_map !== 32'h20) $display("FAIL fwd_ex_busy got %h want 00000020", busy_map); else pass_cnt++;
    endtask

    task automatic test_load_use();
        do_rst();
        put(32'h0081a283, 1, 0);
        put(32'h00728333, 1, 0);
        total++; if (stall !== 1'b1) $display("FAIL ldu_stall got %b want 1", stall); else pass_cnt++;
        total++; if (issue !== 1'b0) $display("FAIL ldu_issue got %b want 0", issue); else pass_cnt++;
        put(32'h00728333, 1, 0);
        total++; if (stall_count !== 16'd1) $display("FAIL ldu_count got %0d want 1", stall_count); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL ldu_stall2 got %b want 0", stall); else pass_cnt++;
        total++; if (fwd_rs1_sel !== 2'd2) $display("FAIL ldu_sel1 got %0d want 2", fwd_rs1_sel); else pass_cnt++;
        total++; if (issue !== 1'b1) $display("FAIL ldu_issue2 got %b want 1", issue); else pass_cnt++;
    endtask

    task automatic test_x0();
        do_rst();
        put(32'h00100013, 1, 0);
        put(32'h000000b3, 1, 0);
        total++; if (fwd_rs1_sel !== 2'd0 || fwd_rs2_sel !== 2'd0)
            $display("FAIL x0_sel got %0d/%0d want 0/0", fwd_rs1_sel, fwd_rs2_sel); else pass_cnt++;
        total++; if (stall !== 1'b0) $display("FAIL x0_stall got %b want 0", stall); else pass_cnt++;
        total++; if (busy_map !== 32'd0) $display("FAIL x0_busy got %h want 0", busy_map); else pass_cnt++;
    endtask

    task automatic test_distance();
        for (int n = 1; n <= 4; n++) begin
            do_rst();
            put(32'h007302b3, 1, 0);
            repeat (n - 1) put(32'h00000013, 1, 0);
            put(rtype(10, 5, 0), 1, 0);
            total++; if (fwd_rs1_sel !== 2'((n < 4) ? n : 0))
                $display("FAIL dist%0d_sel1 got %0d want %0d", n, fwd_rs1_sel, (n < 4) ? n : 0); else pass_cnt++;
        end
    endtask

    task automatic test_flush_hazard();
        do_rst();
        put(32'h0081a283, 1, 0);
        put(32'h00728333, 1, 1);
        total++; if (stall !== 1'b0) $display("FAIL flush_stall got %b want 0", stall); else pass_cnt++;
        total++; if (issue !== 1'b0) $display("FAIL flush_issue got %b want 0", issue); else pass_cnt++;
        put(32'h00728333, 1, 0);
        total++; if (fwd_rs1_sel !== 2'd2) $display("FAIL flush_bubble_sel1 got %0d want 2", fwd_rs1_sel); else pass_cnt++;
        total++; if (busy_map !== 32'h20) $display("FAIL flush_busy got %h want 00000020", busy_map); else pass_cnt++;
        total++; if (stall_count !== 16'd0) $display("FAIL flush_count got %0d want 0", stall_count); else pass_cnt++;
    endtask

    task automatic test_rst_mid();
        do_rst();
        put(32'h0081a283, 1, 0);
        put(32'h00728333, 1, 0);
        put(rtype(1, 0, 0), 1, 0);
        put(rtype(2, 0, 0), 1, 0);
        put(rtype(3, 0, 0), 1, 0);
        put(32'h00000013, 1, 0);
        total++; if (busy_map !== 32'he) $display("FAIL mid_busy_pre got %h want 0000000e", busy_map); else pass_cnt++;
        @(negedge clk);
        rst = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flush = 1'b0;
        #1;
        total++; if (busy_map !== 32'd0) $display("FAIL mid_busy got %h want 0", busy_map); else pass_cnt++;
        total++; if (stall_count !== 16'd0) $display("FAIL mid_count got %0d want 0", stall_count); else pass_cnt++;
        total++; if (issue !== 1'b1) $display("FAIL mid_issue got %b want 1", issue); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_rst();
        repeat (20) put(32'h0002a283, 1, 0);
        @(negedge clk);
        id_valid = 1'b0;
        #1;
        total++; if (stall_count !== 16'd10) $display("FAIL sat_count got %0d want 10", stall_count); else pass_cnt++;
        total++; if (s_count !== 3'd7) $display("FAIL sat_small got %0d want 7", s_count); else pass_cnt++;
    endtask

    task automatic test_random();
        int e1, e2;
        do_rst();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst = ($urandom_range(199) == 0);
            id_valid = ($urandom_range(7) != 0);
            flush = ($urandom_range(7) == 0);
            id_rs1_addr = 5'($urandom_range(7));
            id_rs2_addr = 5'($urandom_range(7));
            id_rd_addr = 5'($urandom_range(7));
            id_uses_rs1 = 1'($urandom);
            id_uses_rs2 = 1'($urandom);
            id_writes_rd = 1'($urandom);
            id_is_load = 1'($urandom);
            #1;
            if (!rst) begin
                e1 = exp_sel(id_uses_rs1, id_rs1_addr);
                e2 = exp_sel(id_uses_rs2, id_rs2_addr);
                total++; if (stall !== exp_stall()) $display("FAIL rnd_stall c%0d got %b want %b", c, stall, exp_stall()); else pass_cnt++;
                total++; if (issue !== exp_issue()) $display("FAIL rnd_issue c%0d got %b want %b", c, issue, exp_issue()); else pass_cnt++;
                total++; if (busy_map !== exp_busy()) $display("FAIL rnd_busy c%0d got %h want %h", c, busy_map, exp_busy()); else pass_cnt++;
                total++; if (stall_count !== 16'(mcnt)) $display("FAIL rnd_count c%0d got %0d want %0d", c, stall_count, mcnt); else pass_cnt++;
                total++; if (s_count !== 3'((mcnt > 7) ? 7 : mcnt)) $display("FAIL rnd_small c%0d got %0d", c, s_count); else pass_cnt++;
                if (e1 >= 0) begin
                    total++; if (fwd_rs1_sel !== 2'(e1)) $display("FAIL rnd_sel1 c%0d got %0d want %0d", c, fwd_rs1_sel, e1); else pass_cnt++;
                end
                if (e2 >= 0) begin
                    total++; if (fwd_rs2_sel !== 2'(e2)) $display("FAIL rnd_sel2 c%0d got %0d want %0d", c, fwd_rs2_sel, e2); else pass_cnt++;
                end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_x0();
        test_distance();
        test_flush_hazard();
        test_rst_mid();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
